cl_axil_reg_bank: RTL
=====================

// Module: cl_axil_reg_bank
// PURPOSE
//  Parametrised AXI-Lite slave register bank for the OCL BAR0 path, behind the AXI-L register slice.
//  - Provides NUM_REGS 32-bit registers with byte strobes and per-register read-only/byte-swap modes.
//  - Returns proper SLVERR/DECERR responses.
//  - Accepts AW and W independently.
//  - Drives a virtual-LED output masked by the virtual DIP switches.
// PARAMETERS
//  NUM_REGS   8             number of 32-bit registers (1..64)
//  BASE_ADDR  32'h0000_0500 byte address of register 0; registers are word-spaced
//  RO_MASK    '0            bit i=1: reg i is read-only and reads ro_in[i]
//  SWAP_MASK  '0            bit i=1: reg i is returned byte-swapped on read
//  VLED_IDX   0             register whose [15:0] feeds vled_out
//  UNIMPL_VAL 32'hDEAD_DEAD rdata for undecoded reads
// PORTS
//  clk_main_a0  in   1            clock
//  rst_main     in   1            reset, asynchronous, active-high
//  s_awvalid/s_awready  in/out  1   write address handshake
//  s_awaddr     in   32           write byte address
//  s_wvalid/s_wready    in/out  1   write data handshake
//  s_wdata      in   32           write data
//  s_wstrb      in   4            byte enables
//  s_bvalid/s_bready    out/in  1   write response handshake
//  s_bresp      out  2            00 OKAY, 10 SLVERR, 11 DECERR
//  s_arvalid/s_arready  in/out  1   read address handshake
//  s_araddr     in   32           read byte address
//  s_rvalid/s_rready    out/in  1   read data handshake
//  s_rdata      out  32           read data
//  s_rresp      out  2            read response code
//  ro_in        in   32*NUM_REGS  values for read-only registers
//  reg_out      out  32*NUM_REGS  current writable register contents
//  wr_pulse     out  NUM_REGS     one-cycle strobe per committed write
//  vdip_in      in   16           virtual DIP switches (asynchronous)
//  vled_out     out  16           virtual LEDs
// BEHAVIOUR
//  Reset:
//  - All registers, reg_out, wr_pulse, vled_out, s_bvalid, s_rvalid, s_rdata, s_bresp, s_rresp and both DIP sync stages are 0.
//  - Write FSM returns to W_IDLE. Reset mid-transaction drops the transaction.
//  Decode:
//  - off = addr - BASE_ADDR.
//  - Hit when off[1:0]==0 and off[31:2] < NUM_REGS; index = off>>2.
//  - Miss (misaligned or out of range) -> DECERR.
//  Write FSM: W_IDLE, W_GOT_AW, W_GOT_W, W_RESP.
//  - s_awready = state in {W_IDLE, W_GOT_W}.
//  - s_wready = state in {W_IDLE, W_GOT_AW}.
//  - AW alone: IDLE -> GOT_AW, address latched. W alone: IDLE -> GOT_W, data and strobe latched.
//  - Both handshakes in the same cycle, or the missing half arriving: commit at that edge -> W_RESP.
//  - Commit on a hit to a writable reg: update bytes whose wstrb bit is 1; OKAY; wr_pulse[idx] high for the following cycle.
//  - Commit to an RO reg: no update; SLVERR. Commit on a miss: no update; DECERR.
//  - s_bvalid is high in W_RESP, i.e. the cycle after commit. Held until s_bready; then -> W_IDLE.
//  - wstrb==0 to a writable hit: OKAY, no byte changes, wr_pulse still fires.
//  Read:
//  - s_arready = !s_rvalid. Handshake samples register contents at that edge.
//  - s_rvalid rises next cycle (latency 1) and holds rdata/rresp stable until s_rready.
//  - Hit: data is ro_in[idx] if RO_MASK[idx], else reg[idx]; byte-reversed if SWAP_MASK[idx]; OKAY.
//  - Miss: UNIMPL_VAL with DECERR.
//  - Read and write to the same reg on the same edge: read returns the pre-write value.
//  VLED:
//  - vdip_in passes through 2 sync flops.
//  - vled_out <= reg[VLED_IDX][15:0] & vdip_sync, registered; 3-cycle latency from a vdip change.
//  Channels: read and write channels are fully independent; no cross-blocking.
// TESTING
//  - Write 0x12345678 strb F to reg0 (SWAP_MASK[0]=1) -> bresp 00, wr_pulse[0]; read reg0 -> 0x78563412, rresp 00.
//  - W issued 3 cycles before AW to reg1 -> awready/wready per FSM; bvalid exactly 1 cycle after AW handshake.
//  - Write 0xAABBCCDD strb 0101 over 0 -> reg reads 0x00BB00DD.
//  - RO reg write -> SLVERR, contents unchanged. Addr BASE+4*NUM_REGS or BASE+2 -> DECERR; read returns 0xDEADDEAD.
//  - bready held low 10 cycles -> bvalid and bresp stable; awready low throughout; read traffic still completes.
//  - vdip=0x00FF, reg[VLED_IDX]=0xF0F0 -> vled_out=0x00F0; assert rst_main mid-write -> outputs 0 asynchronously; next write completes normally.

Source files
------------

// File: rtl/cl_axil_reg_bank.sv
// AXI-Lite slave register bank: NUM_REGS 32-bit registers with byte strobes,
// per-register read-only and byte-swap modes, OKAY/SLVERR/DECERR responses,
// independent AW/W acceptance and a DIP-masked virtual-LED output.
module cl_axil_reg_bank #(
  parameter int                  NUM_REGS   = 8,
  parameter logic [31:0]         BASE_ADDR  = 32'h0000_0500,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0] SWAP_MASK  = '0,
  parameter int                  VLED_IDX   = 0,
  parameter logic [31:0]         UNIMPL_VAL = 32'hDEAD_DEAD
) (
  input  logic                     clk_main_a0,
  input  logic                     rst_main,
  input  logic                     s_awvalid,
  output logic                     s_awready,
  input  logic [31:0]              s_awaddr,
  input  logic                     s_wvalid,
  output logic                     s_wready,
  input  logic [31:0]              s_wdata,
  input  logic [3:0]               s_wstrb,
  output logic                     s_bvalid,
  input  logic                     s_bready,
  output logic [1:0]               s_bresp,
  input  logic                     s_arvalid,
  output logic                     s_arready,
  input  logic [31:0]              s_araddr,
  output logic                     s_rvalid,
  input  logic                     s_rready,
  output logic [31:0]              s_rdata,
  output logic [1:0]               s_rresp,
  input  logic [32*NUM_REGS-1:0]   ro_in,
  output logic [32*NUM_REGS-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      wr_pulse,
  input  logic [15:0]              vdip_in,
  output logic [15:0]              vled_out
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_GOT_AW = 2'd1,
    W_GOT_W  = 2'd2,
    W_RESP   = 2'd3
  } wstate_t;

  wstate_t wstate, wstate_nxt;

  // Reverse byte order of a 32-bit word.
  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic [31:0] regs [NUM_REGS];
  logic [31:0] ro_arr [NUM_REGS];

  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [31:0] cm_addr, cm_data, cm_off;
  logic [3:0]  cm_strb;
  logic        cm_hit, cm_ro;
  logic [IDX_W-1:0] cm_idx;

  logic [31:0] rd_off, rd_word, rd_sel;
  logic        rd_hit;
  logic [IDX_W-1:0] rd_idx;

  logic [15:0] dip_s1, dip_s2;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_flat
      assign ro_arr[g]            = ro_in[32*g +: 32];
      assign reg_out[32*g +: 32]  = regs[g];
    end
  endgenerate

  assign s_awready = (wstate == W_IDLE) || (wstate == W_GOT_W);
  assign s_wready  = (wstate == W_IDLE) || (wstate == W_GOT_AW);
  assign s_bvalid  = (wstate == W_RESP);
  assign s_arready = !s_rvalid;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid  && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  // Commit happens on the edge where the second half of a write arrives
  // (or both halves together); pick latched or live fields accordingly.
  always_comb begin
    commit  = ((wstate == W_IDLE)   && aw_hs && w_hs) ||
              ((wstate == W_GOT_AW) && w_hs) ||
              ((wstate == W_GOT_W)  && aw_hs);
    cm_addr = (wstate == W_GOT_AW) ? aw_addr_q : s_awaddr;
    cm_data = (wstate == W_GOT_W)  ? w_data_q  : s_wdata;
    cm_strb = (wstate == W_GOT_W)  ? w_strb_q  : s_wstrb;
    cm_off  = cm_addr - BASE_ADDR;
    cm_hit  = (cm_off[1:0] == 2'b00) && ({2'b00, cm_off[31:2]} < 32'(NUM_REGS));
    cm_idx  = cm_off[IDX_W+1:2];
    cm_ro   = cm_hit && RO_MASK[cm_idx];
  end

  // Read-side decode and data selection (RO source, then optional swap).
  always_comb begin
    rd_off  = s_araddr - BASE_ADDR;
    rd_hit  = (rd_off[1:0] == 2'b00) && ({2'b00, rd_off[31:2]} < 32'(NUM_REGS));
    rd_idx  = rd_off[IDX_W+1:2];
    rd_word = RO_MASK[rd_idx] ? ro_arr[rd_idx] : regs[rd_idx];
    rd_sel  = SWAP_MASK[rd_idx] ? byte_swap(rd_word) : rd_word;
  end

  // Write FSM next-state logic.
  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) wstate_nxt = W_RESP;
        else if (aw_hs)    wstate_nxt = W_GOT_AW;
        else if (w_hs)     wstate_nxt = W_GOT_W;
      end
      W_GOT_AW: if (w_hs)     wstate_nxt = W_RESP;
      W_GOT_W:  if (aw_hs)    wstate_nxt = W_RESP;
      W_RESP:   if (s_bready) wstate_nxt = W_IDLE;
      default:  wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) wstate <= W_IDLE;
    else          wstate <= wstate_nxt;
  end

  // Hold whichever half of a write arrives first.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= s_awaddr;
      if (w_hs) begin
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end
    end
  end

  // Register update, write response code and one-cycle commit strobe.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      s_bresp  <= RESP_OKAY;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        if (!cm_hit) begin
          s_bresp <= RESP_DECERR;
        end else if (cm_ro) begin
          s_bresp <= RESP_SLVERR;
        end else begin
          regs[cm_idx]     <= strb_merge(regs[cm_idx], cm_data, cm_strb);
          s_bresp          <= RESP_OKAY;
          wr_pulse[cm_idx] <= 1'b1;
        end
      end
    end
  end

  // Read channel: sample on AR handshake, hold until the master takes it.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_hit ? rd_sel : UNIMPL_VAL;
      s_rresp  <= rd_hit ? RESP_OKAY : RESP_DECERR;
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

  // Two-flop synchroniser for the DIP switches, then the masked LED register.
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      dip_s1   <= '0;
      dip_s2   <= '0;
      vled_out <= '0;
    end else begin
      dip_s1   <= vdip_in;
      dip_s2   <= dip_s1;
      vled_out <= regs[VLED_IDX][15:0] & dip_s2;
    end
  end

endmodule
